// File: rtl/cla_seq_adder.sv
// Multi-cycle carry-lookahead adder/subtractor.
// Resolves one GROUP-bit slice per clock with in-slice lookahead carries,
// passes a registered carry between slices, and accumulates block-level
// propagate/generate for a higher lookahead level.
module cla_seq_adder #(
    parameter int WIDTH = 16,
    parameter int GROUP = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             p_all,
    output logic             g_all
);

    localparam int N  = WIDTH / GROUP;
    localparam int KW = (N > 1) ? $clog2(N) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(N - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             c_q, c_d;
    logic             cmsb_q, cmsb_d;
    logic [KW-1:0]    k_q, k_d;
    logic             pacc_q, pacc_d;
    logic             gacc_q, gacc_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic             p_all_q, p_all_d;
    logic             g_all_q, g_all_d;

    logic [GROUP-1:0] slice_a;
    logic [GROUP-1:0] slice_b;
    logic [GROUP-1:0] pp;
    logic [GROUP-1:0] gg;
    logic [GROUP-1:0] pre_p;
    logic [GROUP-1:0] pre_g;
    logic [GROUP:0]   carry;
    logic [GROUP-1:0] slice_sum;
    logic             slice_p;
    logic             slice_g;
    logic             slice_cout;
    logic [WIDTH-1:0] slice_ext;
    logic             load;

    // Lookahead slice: prefix P/G over the low GROUP bits of the shifted operands, every carry taken straight from the slice base carry.
    always_comb begin
        slice_a  = a_q[GROUP-1:0];
        slice_b  = b_q[GROUP-1:0];
        pp       = slice_a ^ slice_b;
        gg       = slice_a & slice_b;
        pre_p    = '0;
        pre_g    = '0;
        pre_p[0] = pp[0];
        pre_g[0] = gg[0];
        for (int i = 1; i < GROUP; i++) begin
            pre_g[i] = gg[i] | (pp[i] & pre_g[i-1]);
            pre_p[i] = pp[i] & pre_p[i-1];
        end
        carry    = '0;
        carry[0] = c_q;
        for (int i = 0; i < GROUP; i++) begin
            carry[i+1] = pre_g[i] | (pre_p[i] & c_q);
        end
        slice_sum  = pp ^ carry[GROUP-1:0];
        slice_p    = pre_p[GROUP-1];
        slice_g    = pre_g[GROUP-1];
        slice_cout = carry[GROUP];
        slice_ext  = '0;
        slice_ext[GROUP-1:0] = slice_sum;
    end

    // Next-state logic: operands shift down one slice per RUN cycle, results publish from DONE, and a new request loads from IDLE or DONE.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        c_d     = c_q;
        cmsb_d  = cmsb_q;
        k_d     = k_q;
        pacc_d  = pacc_q;
        gacc_d  = gacc_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        p_all_d = p_all_q;
        g_all_d = g_all_q;
        load    = 1'b0;

        case (state_q)
            IDLE: begin
                load = start;
            end
            RUN: begin
                a_d    = a_q >> GROUP;
                b_d    = b_q >> GROUP;
                res_d  = (res_q >> GROUP) | (slice_ext << (WIDTH - GROUP));
                c_d    = slice_cout;
                pacc_d = pacc_q & slice_p;
                gacc_d = slice_g | (slice_p & gacc_q);
                k_d    = k_q + 1'b1;
                if (k_q == K_LAST) begin
                    cmsb_d  = carry[GROUP-1];
                    state_d = DONE;
                    busy_d  = 1'b0;
                end
            end
            DONE: begin
                done_d  = 1'b1;
                sum_d   = res_q;
                cout_d  = c_q;
                ovf_d   = cmsb_q ^ c_q;
                p_all_d = pacc_q;
                g_all_d = gacc_q;
                state_d = IDLE;
                load    = start;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (load) begin
            a_d     = a;
            b_d     = sub ? ~b : b;
            c_d     = sub ? 1'b1 : cin;
            res_d   = '0;
            cmsb_d  = 1'b0;
            k_d     = '0;
            pacc_d  = 1'b1;
            gacc_d  = 1'b0;
            busy_d  = 1'b1;
            state_d = RUN;
        end
    end

    // State and output registers; reset discards any in-flight operation.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            c_q     <= 1'b0;
            cmsb_q  <= 1'b0;
            k_q     <= '0;
            pacc_q  <= 1'b0;
            gacc_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            p_all_q <= 1'b0;
            g_all_q <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            c_q     <= c_d;
            cmsb_q  <= cmsb_d;
            k_q     <= k_d;
            pacc_q  <= pacc_d;
            gacc_q  <= gacc_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            p_all_q <= p_all_d;
            g_all_q <= g_all_d;
        end
    end

    assign busy  = busy_q;
    assign done  = done_q;
    assign sum   = sum_q;
    assign cout  = cout_q;
    assign ovf   = ovf_q;
    assign p_all = p_all_q;
    assign g_all = g_all_q;

endmodule

// File: tb/tb_cla_seq_adder.sv
// Bench for cla_seq_adder: directed and random operations against a plain
// arithmetic reference, plus handshake timing, hold, reset and GROUP=WIDTH cases.
module tb_cla_seq_adder;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         start16;
    logic         sub;
    logic         cin;
    logic [W-1:0] a;
    logic [W-1:0] b;

    logic         busy, done, cout, ovf, p_all, g_all;
    logic [W-1:0] sum;
    logic         busy16, done16, cout16, ovf16, p_all16, g_all16;
    logic [W-1:0] sum16;

    int           total = 0;
    int           bad   = 0;

    logic [W-1:0] exp_sum;
    logic         exp_cout, exp_ovf, exp_p, exp_g;
    logic [W-1:0] held_sum;

    cla_seq_adder #(.WIDTH(W), .GROUP(4)) dut (
        .clk(clk), .rst(rst), .start(start), .sub(sub), .a(a), .b(b), .cin(cin),
        .busy(busy), .done(done), .sum(sum), .cout(cout), .ovf(ovf),
        .p_all(p_all), .g_all(g_all)
    );

    cla_seq_adder #(.WIDTH(W), .GROUP(W)) dut16 (
        .clk(clk), .rst(rst), .start(start16), .sub(sub), .a(a), .b(b), .cin(cin),
        .busy(busy16), .done(done16), .sum(sum16), .cout(cout16), .ovf(ovf16),
        .p_all(p_all16), .g_all(g_all16)
    );

    always #5 clk = ~clk;

    // Reference: whole-word arithmetic on the effective operands.
    task automatic setModel(input logic [W-1:0] av, input logic [W-1:0] bv,
                            input logic sv, input logic cv);
        logic [W-1:0] be;
        logic         c0;
        logic [W:0]   full;
        logic [W-1:0] low;
        logic [W:0]   gen;
        be       = sv ? ~bv : bv;
        c0       = sv ? 1'b1 : cv;
        full     = {1'b0, av} + {1'b0, be} + {{W{1'b0}}, c0};
        low      = {1'b0, av[W-2:0]} + {1'b0, be[W-2:0]} + {{(W-1){1'b0}}, c0};
        gen      = {1'b0, av} + {1'b0, be};
        exp_sum  = full[W-1:0];
        exp_cout = full[W];
        exp_ovf  = low[W-1] ^ full[W];
        exp_p    = &(av ^ be);
        exp_g    = gen[W];
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic checkResult(input string tag);
        checkOutput({tag, "_sum"},  32'(sum),   32'(exp_sum));
        checkOutput({tag, "_cout"}, 32'(cout),  32'(exp_cout));
        checkOutput({tag, "_ovf"},  32'(ovf),   32'(exp_ovf));
        checkOutput({tag, "_pall"}, 32'(p_all), 32'(exp_p));
        checkOutput({tag, "_gall"}, 32'(g_all), 32'(exp_g));
    endtask

    // Called #1 after an edge; leaves the bench #1 after the edge that sampled start.
    task automatic applyStimulus(input logic [W-1:0] av, input logic [W-1:0] bv,
                                 input logic sv, input logic cv);
        a     = av;
        b     = bv;
        sub   = sv;
        cin   = cv;
        setModel(av, bv, sv, cv);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Waits (bounded) for done, checking latency, busy length, hold, result and pulse width.
    task automatic waitDone(input string tag, input int want_lat);
        int cyc  = 0;
        int bcnt = 0;
        do begin
            if (busy) bcnt++;
            if (cyc == 2) checkOutput({tag, "_hold"}, 32'(sum), 32'(held_sum));
            @(posedge clk); #1;
            cyc++;
        end while (!done && cyc < 30);
        checkOutput({tag, "_latency"}, 32'(cyc), 32'(want_lat));
        checkOutput({tag, "_busycycles"}, 32'(bcnt), 32'(want_lat - 1));
        checkResult(tag);
        held_sum = exp_sum;
        @(posedge clk); #1;
        checkOutput({tag, "_donepulse"}, 32'(done), 32'd0);
    endtask

    initial begin
        int dcnt;
        int cyc;
        rst      = 1'b1;
        start    = 1'b0;
        start16  = 1'b0;
        sub      = 1'b0;
        cin      = 1'b0;
        a        = '0;
        b        = '0;
        held_sum = '0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
        checkOutput("rst_sum",  32'(sum),  32'd0);
        checkOutput("rst_flags", {28'd0, cout, ovf, p_all, g_all}, 32'd0);
        checkOutput("rst_sum16", 32'(sum16), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        $display("[TB] directed vectors");
        applyStimulus(16'h00FF, 16'h0001, 1'b0, 1'b0);
        waitDone("t1", 5);
        checkOutput("t1_const_sum", 32'(sum), 32'h0100);

        applyStimulus(16'hFFFF, 16'h0001, 1'b0, 1'b0);
        waitDone("t2", 5);
        checkOutput("t2_const_cout_gall", {30'd0, cout, g_all}, 32'd3);

        applyStimulus(16'h7FFF, 16'h0001, 1'b0, 1'b0);
        waitDone("t3_add", 5);
        checkOutput("t3_const_ovf", 32'(ovf), 32'd1);

        applyStimulus(16'h0005, 16'h0007, 1'b1, 1'b1);
        waitDone("t3_sub", 5);
        checkOutput("t3_const_diff", 32'(sum), 32'hFFFE);

        applyStimulus(16'hAAAA, 16'h5555, 1'b0, 1'b1);
        waitDone("t4_cin1", 5);
        checkOutput("t4_const_pall", {30'd0, p_all, g_all}, 32'd2);

        applyStimulus(16'hAAAA, 16'h5555, 1'b0, 1'b0);
        waitDone("t4_cin0", 5);
        checkOutput("t4_const_sum", 32'(sum), 32'hFFFF);

        $display("[TB] start ignored while busy");
        applyStimulus(16'h1234, 16'h1111, 1'b0, 1'b0);
        @(posedge clk); #1;
        a     = 16'hFFFF;
        b     = 16'hFFFF;
        sub   = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        waitDone("t5_ignore", 3);
        checkOutput("t5_const_sum", 32'(sum), 32'h2345);

        $display("[TB] back-to-back start in DONE cycle");
        applyStimulus(16'h0F0F, 16'h0101, 1'b0, 1'b1);
        repeat (4) begin @(posedge clk); #1; end
        checkOutput("t5_done_state_busy", 32'(busy), 32'd0);
        checkOutput("t5_done_state_done", 32'(done), 32'd0);
        a     = 16'h8000;
        b     = 16'h0001;
        sub   = 1'b1;
        cin   = 1'b0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        checkOutput("t5_b2b_done", 32'(done), 32'd1);
        checkOutput("t5_b2b_busy", 32'(busy), 32'd1);
        checkResult("t5_b2b_first");
        held_sum = exp_sum;
        setModel(16'h8000, 16'h0001, 1'b1, 1'b0);
        waitDone("t5_b2b_second", 5);

        $display("[TB] reset mid-run");
        applyStimulus(16'h4321, 16'h1234, 1'b0, 1'b0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checkOutput("t6_rst_busy", 32'(busy), 32'd0);
        checkOutput("t6_rst_sum",  32'(sum),  32'd0);
        checkOutput("t6_rst_done", 32'(done), 32'd0);
        dcnt = 0;
        repeat (8) begin
            @(posedge clk); #1;
            if (done) dcnt++;
        end
        checkOutput("t6_no_done", 32'(dcnt), 32'd0);
        held_sum = '0;
        applyStimulus(16'hC000, 16'h4001, 1'b0, 1'b1);
        waitDone("t6_fresh", 5);

        $display("[TB] random operations");
        for (int n = 0; n < 20; n++) begin
            applyStimulus(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
            waitDone($sformatf("rand%0d", n), 5);
        end

        $display("[TB] GROUP equals WIDTH");
        a       = 16'h00FF;
        b       = 16'h0001;
        sub     = 1'b0;
        cin     = 1'b0;
        setModel(16'h00FF, 16'h0001, 1'b0, 1'b0);
        start16 = 1'b1;
        @(posedge clk); #1;
        start16 = 1'b0;
        cyc = 0;
        do begin
            @(posedge clk); #1;
            cyc++;
        end while (!done16 && cyc < 30);
        checkOutput("g16_latency", 32'(cyc), 32'd2);
        checkOutput("g16_sum", 32'(sum16), 32'(exp_sum));
        checkOutput("g16_flags", {28'd0, cout16, ovf16, p_all16, g_all16},
                    {28'd0, exp_cout, exp_ovf, exp_p, exp_g});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cla_seq_adder.md
Name: cla_seq_adder

Overview:
Parametrised, multi-cycle carry-lookahead adder/subtractor and the successor to the fixed 2-bit PG unit. Each cycle it processes one GROUP-bit slice:
- per-bit propagate/generate,
- in-group lookahead carries,
- a registered carry passed between slices.
It also accumulates block-level P/G for use by a higher lookahead level and reports completion with a start/busy/done handshake.

Parameters:
WIDTH, 16, operand/result width in bits; must be an integer multiple of GROUP.
GROUP, 4, bits resolved per cycle by the lookahead slice. N = WIDTH/GROUP slices.

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous reset, active-high
start  input  1  request; sampled only when not busy
sub  input  1  0 = add, 1 = subtract (a - b); sampled with start
a  input  WIDTH  operand A; sampled with start
b  input  WIDTH  operand B; sampled with start
cin  input  1  carry-in for add; ignored when sub = 1
busy  output  1  high while the slice iteration runs
done  output  1  one-cycle pulse when results become valid
sum  output  WIDTH  result; held until the next completion
cout  output  1  carry out of the MSB
ovf  output  1  signed overflow = carry into MSB XOR cout
p_all  output  1  block propagate: AND of all per-bit p over the effective operands
g_all  output  1  block generate of the effective operands, excluding carry-in

Behaviour:
- Clock and reset: one clock (clk); rst is synchronous and active-high.
- Reset values: busy, done, sum, cout, ovf, p_all, g_all all 0. FSM state = IDLE. Internal operand, carry and slice-index registers are cleared.
- FSM has three states: IDLE, RUN, DONE.
- IDLE, on start = 1:
  - latch A = a;
  - latch B = sub ? ~b : b;
  - set C = sub ? 1 : cin;
  - clear slice index k = 0;
  - seed accumulators Pacc = 1, Gacc = 0;
  - go to RUN; busy = 1 from the next cycle.
- RUN, one slice per cycle, bits i = k*GROUP .. k*GROUP+GROUP-1:
  - p_i = A_i ^ B_i; g_i = A_i & B_i;
  - c_(i+1) = g_i | (p_i & c_i), with slice base carry = C;
  - s_i = p_i ^ c_i;
  - slice P = AND of its p_i; slice G = lookahead generate of the slice;
  - Pacc <= Pacc & P; Gacc <= G | (P & Gacc);
  - C <= slice carry-out; k <= k+1.
  - After slice N-1, go to DONE.
  - Carries inside a slice are combinational lookahead, not ripple across registers. Only the slice carry-out is registered.
- DONE (one cycle):
  - done = 1, busy = 0;
  - sum, cout, ovf, p_all, g_all registered from the internal results;
  - ovf uses the carry into bit WIDTH-1 captured during the last slice.
  - Next state is IDLE, or RUN if start = 1 in this cycle (back-to-back; the new operands are latched).
- Latency: start sampled at edge t gives done high for the cycle after edge t+N+1 (N+1 cycles of busy/done). With the defaults, done appears 5 cycles after start.
- Outputs sum/cout/ovf/p_all/g_all change only on a DONE cycle or on reset; otherwise they hold.
- start while busy = 1 (RUN): ignored. No queuing, and latched operands are unaffected.
- Operand changes during RUN: no effect.
- rst during RUN or DONE: takes priority over everything. Next cycle is IDLE with all outputs 0, and the in-flight operation is discarded with no done pulse.
- Wrap-around: the sum is modulo 2^WIDTH; carry beyond the MSB appears only on cout.
- GROUP = WIDTH is legal (N = 1, 2-cycle latency). GROUP = 1 degenerates to bit-serial.

Test Plan:
(WIDTH = 16, GROUP = 4 unless noted)
1. add 0x00FF + 0x0001, cin = 0 → sum = 0x0100, cout = 0, ovf = 0, p_all = 0. busy high for 4 cycles, done pulse exactly 5 cycles after start.
2. add 0xFFFF + 0x0001, cin = 0 → sum = 0x0000, cout = 1, ovf = 0, p_all = 0, g_all = 1.
3. add 0x7FFF + 0x0001, cin = 0 → sum = 0x8000, cout = 0, ovf = 1. Then sub 0x0005 - 0x0007 with cin = 1 (ignored) → sum = 0xFFFE, cout = 0, ovf = 0.
4. add 0xAAAA + 0x5555, cin = 1 → full-length propagate: sum = 0x0000, cout = 1, p_all = 1, g_all = 0. With cin = 0 → sum = 0xFFFF, cout = 0.
5. start pulsed during RUN with different operands → ignored, original result delivered. start held during the DONE cycle → second operation begins immediately and its done follows 5 cycles later.
6. rst asserted at cycle 2 of RUN → next cycle busy = 0, sum = 0, no done pulse. A fresh start then completes correctly. Repeat test 1 with GROUP = 16 → done after 2 cycles.
